// File: rtl/bus_mux_reg.sv
// Registered one-hot bus source multiplexer with bus keeper, stall and conflict counting.
// Define BUS_PARITY_EN to add the registered even-parity output bus_par.
module bus_mux_reg #(
    parameter int N    = 24,
    parameter int W    = 32,
    parameter int SELW = (N > 1) ? $clog2(N) : 1,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    src_data,
    input  logic [N-1:0]      src_oe,
    input  logic              hold,
    input  logic              clr_err,
    output logic [W-1:0]      bus_out,
    output logic              bus_valid,
    output logic [SELW-1:0]   bus_src,
    output logic              conflict,
`ifdef BUS_PARITY_EN
    output logic              bus_par,
`endif
    output logic [CNTW-1:0]   conflict_cnt
);

    logic            any_oe;
    logic            multi_oe;
    logic [SELW-1:0] sel_idx;
    logic [W-1:0]    sel_word;

    // Scan from the top so the lowest-index enabled source is written last and wins.
    always_comb begin
        any_oe   = 1'b0;
        multi_oe = 1'b0;
        sel_idx  = '0;
        sel_word = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (src_oe[i]) begin
                sel_idx  = SELW'(i);
                sel_word = src_data[i*W +: W];
            end
        end
        for (int i = 0; i < N; i++) begin
            multi_oe = multi_oe | (any_oe & src_oe[i]);
            any_oe   = any_oe | src_oe[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
            bus_src   <= '0;
        end else if (!hold) begin
            bus_valid <= any_oe;
            if (any_oe) begin
                bus_out <= sel_word;
                bus_src <= sel_idx;
            end
        end
    end

    // A clear in the same cycle as a conflict still records that conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else if (!hold) begin
            if (clr_err) begin
                conflict     <= multi_oe;
                conflict_cnt <= multi_oe ? CNTW'(1) : '0;
            end else if (multi_oe) begin
                conflict <= 1'b1;
                if (conflict_cnt != {CNTW{1'b1}}) begin
                    conflict_cnt <= conflict_cnt + CNTW'(1);
                end
            end
        end
    end

`ifdef BUS_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_par <= 1'b0;
        end else if (!hold && any_oe) begin
            bus_par <= ^sel_word;
        end
    end
`endif

endmodule
